seg7_scan_decoder: RTL and testbench
====================================

# seg7_scan_decoder

Recovers hex digit values from a time-multiplexed, active-low 7-segment display bus (segment lines plus one-hot digit enables). It performs the inverse mapping of our hex-to-segment display decoder. It sits on the debug/self-check path beside the display driver, so the FPGA can read back exactly what the HEX displays show. The block synchronizes and stability-filters the bus, decodes each accepted digit, and publishes a packed value with a frame-complete strobe.

## Interface
- DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before a digit is accepted (2..255).
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- seg_in  in  7  segment lines, active-low, bit0=a … bit6=g (pattern 7'b1000000 shows "0").
- digit_sel  in  DIGITS  digit enables, active-high, one-hot while a digit is driven.
- value  out  4*DIGITS  decoded nibbles; digit k occupies bits [4k+3:4k].
- digit_valid  out  DIGITS  bit k=1 when the last accepted pattern for digit k was a legal hex glyph.
- frame_valid  out  1  one-cycle pulse after every digit has been accepted at least once since the previous pulse.
- err  out  1  one-cycle pulse when an accepted pattern is neither a legal glyph nor blank.
- err_digit  out  3  index of the digit that caused the last err; holds its value between errors.

## Operation
- Input stage: two-flop synchronizer on {digit_sel, seg_in}. Reset values: seg 7'h7F, sel 0.
- Stability counter: compares the synchronized sample with the previous synchronized sample.
  - Equal: increment, saturating at STABLE_CYCLES.
  - Different: reload to 1.
- Accept: a one-cycle event when the counter reaches exactly STABLE_CYCLES and sel is one-hot. There is at most one accept per stable interval; no re-accept until the sample changes.
- sel zero or multi-hot (blanking/ghosting): never accepted, no outputs change.
- Decode on accept, for selected digit k:
  - Legal glyph (16 patterns 0–F): write the nibble to value[k] and set digit_valid[k].
  - Blank (7'h7F): clear digit_valid[k], value[k] unchanged, no err.
  - Any other pattern: clear digit_valid[k], value[k] unchanged, pulse err, load err_digit=k.
- Frame tracking: seen mask of DIGITS bits.
  - Any accept (legal, blank or illegal) sets bit k.
  - When the mask becomes all-ones, frame_valid pulses on the next cycle and the mask clears in that same cycle.
  - If an accept coincides with the clearing cycle, its bit lands in the freshly cleared mask and is not lost.
- Reset (any time, including mid-frame) clears value, digit_valid, frame_valid, err, err_digit, counter and mask immediately. The first accept requires STABLE_CYCLES fresh samples after release.

## Timing
- Inputs are sampled on rising clk. All outputs are registered.
- Latency: for inputs that change and then stay stable, value/digit_valid/err update STABLE_CYCLES+2 edges after the first edge that captures the new input.
- frame_valid asserts one cycle after the accept that completes the mask.
- Glitches shorter than STABLE_CYCLES synchronized cycles are rejected.
- Minimum digit dwell for capture: STABLE_CYCLES+2 cycles.
- Scan order is free. Repeats of one digit before others only refresh that digit and do not complete the frame.

## Structure
- Package seg7_pkg:
  - Active-low pattern constants SEG_HEX[0:15] and SEG_BLANK=7'h7F, shared with the existing display driver so both directions use one table.
  - Localparam for err_digit width.
- Sub-module seg7_pattern_decode: combinational lookup, seg[6:0] → {nibble[3:0], legal, blank}.
- Top level holds the synchronizer, stability counter, one-hot check, output registers and seen mask.

## Test plan
- Reset release, sel=4'b0001 and seg=7'b0100100 held for 6 cycles → value[3:0]=4'h2 and digit_valid=4'b0001 exactly at edge STABLE_CYCLES+2; err=0.
- Scan four digits with "1","2","3","F" (7'b1111001, 7'b0100100, 7'b0110000, 7'b0001110), dwell 8 each → value=16'hF321, digit_valid=4'hF, frame_valid pulses once, 1 cycle after the 4th accept.
- Digit 2 shows 7'b1010101 → err pulse of 1 cycle, err_digit=2, digit_valid[2]=0, value[11:8] unchanged; frame still completes.
- 2-cycle glitch to 7'b0000000 within a stable "7" dwell → no accept, value unchanged. sel=4'b0110 held 10 cycles → no output change.
- Blank 7'h7F on digit 1 → digit_valid[1]=0, err=0. Repeating digit 0 for ten dwells without other digits → frame_valid never pulses.
- rst_n low mid-frame after 3 digits accepted → all outputs 0 immediately. After release, a full frame is required before frame_valid.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and helpers for the display driver and the
// scan-bus read-back decoder.
package seg7_pkg;

  localparam int ERR_DIGIT_W = 3;
  localparam int MAX_DIGITS  = 8;

  // Active-low glyphs, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_HEX [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [3:0] nibble;
    logic       legal;
    logic       blank;
  } seg_decode_t;

  function automatic logic is_onehot(input logic [MAX_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 8'd1)) == '0);
  endfunction

  function automatic logic [ERR_DIGIT_W-1:0] onehot_index(input logic [MAX_DIGITS-1:0] v);
    onehot_index = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (v[i]) onehot_index = ERR_DIGIT_W'(i);
    end
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-segment table: pattern -> nibble plus
// legal/blank classification.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0]  seg,
  output seg_decode_t dec
);

  always_comb begin
    // NOTE: every field gets a default before the lookup so no path leaves
    // dec unassigned, which would otherwise infer a latch.
    dec       = '0;
    dec.blank = (seg == SEG_BLANK);
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_HEX[i]) begin
        dec.nibble = 4'(i);
        dec.legal  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Read-back of a multiplexed active-low 7-segment bus: synchronize, filter for
// stability, decode each accepted digit and flag completed frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [6:0]             seg_in,
  input  logic [DIGITS-1:0]      digit_sel,
  output logic [4*DIGITS-1:0]    value,
  output logic [DIGITS-1:0]      digit_valid,
  output logic                   frame_valid,
  output logic                   err,
  output logic [ERR_DIGIT_W-1:0] err_digit
);

  localparam int              SW         = DIGITS + 7;
  localparam logic [7:0]      STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [SW-1:0]   SAMPLE_RST = {{DIGITS{1'b0}}, SEG_BLANK};

  logic [SW-1:0]          sync_meta;
  logic [SW-1:0]          sync_out;
  logic [SW-1:0]          sample_prev;
  logic [7:0]             stable_cnt;
  logic [7:0]             stable_cnt_nxt;
  logic [DIGITS-1:0]      sel;
  logic [6:0]             seg;
  logic [DIGITS-1:0]      seen;
  logic [DIGITS-1:0]      accept_bit;
  logic                   sel_onehot;
  logic                   accept;
  logic                   seen_full;
  logic [ERR_DIGIT_W-1:0] sel_index;
  seg_decode_t            dec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta   <= SAMPLE_RST;
      sync_out    <= SAMPLE_RST;
      sample_prev <= SAMPLE_RST;
    end else begin
      // NOTE: non-blocking so each stage takes its neighbour's pre-edge value;
      // blocking would collapse the two-flop synchronizer into one stage.
      sync_meta   <= {digit_sel, seg_in};
      sync_out    <= sync_meta;
      sample_prev <= sync_out;
    end
  end

  assign sel        = sync_out[SW-1:7];
  assign seg        = sync_out[6:0];
  assign sel_onehot = is_onehot(8'(sel));
  assign sel_index  = onehot_index(8'(sel));

  // Run length of identical synchronized samples, saturating at the threshold.
  always_comb begin
    stable_cnt_nxt = 8'd1;
    if (sync_out == sample_prev) begin
      stable_cnt_nxt = (stable_cnt == STABLE_MAX) ? stable_cnt : stable_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stable_cnt <= '0;
    else        stable_cnt <= stable_cnt_nxt;
  end

  // Fires only on the transition into saturation: one accept per stable run.
  assign accept     = sel_onehot && (stable_cnt_nxt == STABLE_MAX) && (stable_cnt != STABLE_MAX);
  assign accept_bit = accept ? sel : '0;

  seg7_pattern_decode u_decode (
    .seg (seg),
    .dec (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value       <= '0;
      digit_valid <= '0;
      err         <= 1'b0;
      err_digit   <= '0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (sel[d]) begin
            if (dec.legal) value[4*d +: 4] <= dec.nibble;
            digit_valid[d] <= dec.legal;
          end
        end
        if (!dec.legal && !dec.blank) begin
          err       <= 1'b1;
          err_digit <= sel_index;
        end
      end
    end
  end

  // A full mask pulses frame_valid and clears in the same cycle; an accept
  // landing in that cycle is OR-ed into the fresh mask.
  assign seen_full = &seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= seen_full;
      seen        <= (seen_full ? '0 : seen) | accept_bit;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: a history-based model checked every
// cycle, plus literal expectations for each scenario.
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int S      = 4;
  localparam int SW     = DIGITS + 7;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [6:0]            seg_in;
  logic [DIGITS-1:0]     digit_sel;
  logic [4*DIGITS-1:0]   value;
  logic [DIGITS-1:0]     digit_valid;
  logic                  frame_valid;
  logic                  err;
  logic [2:0]            err_digit;

  int n_total = 0;
  int n_bad   = 0;
  int frame_cnt = 0;
  int err_cnt   = 0;

  logic [6:0] glyph [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_decoder #(.DIGITS(DIGITS), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .digit_sel   (digit_sel),
    .value       (value),
    .digit_valid (digit_valid),
    .frame_valid (frame_valid),
    .err         (err),
    .err_digit   (err_digit)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the last S+2 captured bus words; an accept happens when the S words
  // before the newest one agree and the word before them differs.
  logic [SW-1:0]     hist [S+2];
  logic [3:0]        m_val [DIGITS];
  logic [DIGITS-1:0] m_dv   = '0;
  logic [DIGITS-1:0] m_seen = '0;
  logic              m_frame = 1'b0;
  logic              m_err   = 1'b0;
  logic              m_full  = 1'b0;
  logic [2:0]        m_err_digit = '0;

  task automatic model_reset();
    for (int i = 0; i < S + 2; i++) hist[i] = {{DIGITS{1'b0}}, 7'h7F};
    for (int i = 0; i < DIGITS; i++) m_val[i] = 4'h0;
    m_dv = '0; m_seen = '0; m_frame = 1'b0; m_err = 1'b0; m_full = 1'b0; m_err_digit = '0;
  endtask

  task automatic model_step();
    logic [DIGITS-1:0] s;
    logic [6:0]        p;
    bit                run;
    int                k;
    int                g;
    run = 1'b1;
    for (int i = 2; i <= S; i++) if (hist[i] != hist[1]) run = 1'b0;
    if (hist[S+1] == hist[1]) run = 1'b0;
    s = hist[1][SW-1:7];
    p = hist[1][6:0];
    m_frame = m_full;
    m_err   = 1'b0;
    if (m_full) m_seen = '0;
    if (run && $countones(s) == 1) begin
      k = 0;
      for (int i = 0; i < DIGITS; i++) if (s[i]) k = i;
      g = -1;
      for (int j = 0; j < 16; j++) if (glyph[j] == p) g = j;
      if (g >= 0) begin
        m_val[k] = 4'(g);
        m_dv[k]  = 1'b1;
      end else begin
        m_dv[k] = 1'b0;
        if (p != 7'h7F) begin
          m_err       = 1'b1;
          m_err_digit = 3'(k);
        end
      end
      m_seen[k] = 1'b1;
    end
    m_full = &m_seen;
    for (int i = S + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {digit_sel, seg_in};
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  initial begin
    logic [4*DIGITS-1:0] exp_value;
    forever begin
      @(negedge clk);
      for (int i = 0; i < DIGITS; i++) exp_value[4*i +: 4] = m_val[i];
      check("model_value",       32'(value),       32'(exp_value));
      check("model_digit_valid", 32'(digit_valid), 32'(m_dv));
      check("model_frame_valid", 32'(frame_valid), 32'(m_frame));
      check("model_err",         32'(err),         32'(m_err));
      check("model_err_digit",   32'(err_digit),   32'(m_err_digit));
      if (frame_valid) frame_cnt++;
      if (err)         err_cnt++;
    end
  end

  task automatic show(input logic [DIGITS-1:0] s, input logic [6:0] p, input int n);
    digit_sel = s;
    seg_in    = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int fc;
    int ec;
    rst_n     = 1'b0;
    digit_sel = '0;
    seg_in    = 7'h7F;
    repeat (3) @(negedge clk);
    check("rst_value",       32'(value),       32'h0);
    check("rst_digit_valid", 32'(digit_valid), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_err",         32'(err),         32'h0);

    // Single digit "2": visible exactly at edge S+2 after release.
    rst_n     = 1'b1;
    digit_sel = 4'b0001;
    seg_in    = glyph[2];
    repeat (S + 1) @(posedge clk);
    #1 check("t1_early_dv", 32'(digit_valid), 32'h0);
    @(posedge clk);
    #1;
    check("t1_value0", 32'(value[3:0]),  32'h2);
    check("t1_dv",     32'(digit_valid), 32'h1);
    check("t1_err",    32'(err),         32'h0);
    @(negedge clk);

    // Full scan 1,2,3,F.
    fc = frame_cnt; ec = err_cnt;
    show(4'b0001, glyph[1],  8);
    show(4'b0010, glyph[2],  8);
    show(4'b0100, glyph[3],  8);
    show(4'b1000, glyph[15], 8);
    check("t2_value",  32'(value),       32'hF321);
    check("t2_dv",     32'(digit_valid), 32'hF);
    check("t2_frames", 32'(frame_cnt - fc), 32'd1);
    check("t2_errs",   32'(err_cnt - ec),   32'd0);

    // Illegal pattern on digit 2.
    fc = frame_cnt; ec = err_cnt;
    show(4'b0001, glyph[4],   8);
    show(4'b0010, glyph[5],   8);
    show(4'b0100, 7'b1010101, 8);
    show(4'b1000, glyph[6],   8);
    check("t3_value",     32'(value),       32'h6354);
    check("t3_dv",        32'(digit_valid), 32'hB);
    check("t3_errs",      32'(err_cnt - ec),   32'd1);
    check("t3_err_digit", 32'(err_digit),   32'd2);
    check("t3_frames",    32'(frame_cnt - fc), 32'd1);

    // Short glitch inside a stable "7", then a multi-hot select.
    ec = err_cnt;
    show(4'b0001, glyph[7],   8);
    show(4'b0001, 7'b0000000, 2);
    show(4'b0001, glyph[7],   8);
    check("t4_glitch_value", 32'(value), 32'h6357);
    show(4'b0110, glyph[8], 10);
    check("t4_multi_value", 32'(value),       32'h6357);
    check("t4_multi_dv",    32'(digit_valid), 32'hB);
    check("t4_errs",        32'(err_cnt - ec), 32'd0);

    // Blank on digit 1, then digit 0 alone for ten dwells.
    ec = err_cnt;
    show(4'b0010, 7'h7F, 8);
    check("t5_blank_dv",   32'(digit_valid), 32'h9);
    check("t5_blank_errs", 32'(err_cnt - ec), 32'd0);
    fc = frame_cnt;
    for (int i = 0; i < 10; i++) show(4'b0001, glyph[i], 8);
    check("t5_repeat_frames", 32'(frame_cnt - fc), 32'd0);
    check("t5_repeat_value",  32'(value), 32'h6359);

    // Reset mid-frame after three digits.
    show(4'b0001, glyph[11], 8);
    show(4'b0010, glyph[12], 8);
    show(4'b0100, glyph[13], 8);
    show(4'b1000, glyph[14], 2);
    #2;
    rst_n     = 1'b0;
    digit_sel = '0;
    seg_in    = 7'h7F;
    #1;
    check("t6_rst_value",     32'(value),       32'h0);
    check("t6_rst_dv",        32'(digit_valid), 32'h0);
    check("t6_rst_frame",     32'(frame_valid), 32'h0);
    check("t6_rst_err",       32'(err),         32'h0);
    check("t6_rst_err_digit", 32'(err_digit),   32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    fc = frame_cnt;
    show(4'b1000, glyph[14], 8);
    show(4'b0001, glyph[10], 8);
    show(4'b0010, glyph[11], 8);
    check("t6_partial_frames", 32'(frame_cnt - fc), 32'd0);
    check("t6_partial_value",  32'(value),       32'hE0BA);
    check("t6_partial_dv",     32'(digit_valid), 32'hB);
    show(4'b0100, glyph[12], 8);
    check("t6_full_frames", 32'(frame_cnt - fc), 32'd1);
    check("t6_full_value",  32'(value),       32'hECBA);
    check("t6_full_dv",     32'(digit_valid), 32'hF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
